// File: rtl/clk_sel_pkg.sv
// Shared encodings for the clock-select controller: FSM states, select values
// and the helper that picks the synchronized branch-enable for a given select.
package clk_sel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ENGAGE = 3'd2,
        ST_SETTLE = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic SEL_CLK1 = 1'b0;
    localparam logic SEL_CLK2 = 1'b1;

    function automatic logic sel_ack(input logic s, input logic a1, input logic a2);
        logic r;
        if (s == SEL_CLK2) begin
            r = a2;
        end else begin
            r = a1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, async active-high reset.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_r;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_r <= {SYNC_STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/clk_sel_ctrl.sv
// Clock-switch controller driving a glitch-free mux select line.
// Optional timeout/ERR handling is built when CLK_SEL_TIMEOUT_EN is defined.
module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DWELL_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic ack_1,
    input  logic ack_2,
    input  logic err_clr,
    output logic sel,
    output logic busy,
    output logic done,
    output logic err
);

    logic   a1_s;
    logic   a2_s;
    logic   a_old_s;
    logic   a_new_s;
    logic   accept_s;
    state_t state_r;
    logic   cur_sel_r;
    logic   sel_r;
    logic   req_ready_r;
    logic   busy_r;
    logic   done_r;
    logic [CNT_W-1:0] dcnt_r;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1 (
        .clk   (clk),
        .reset (reset),
        .d     (ack_1),
        .q     (a1_s)
    );

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_2 (
        .clk   (clk),
        .reset (reset),
        .d     (ack_2),
        .q     (a2_s)
    );

    // Old branch is the one currently confirmed; new branch is the one now selected.
    always_comb begin
        a_old_s  = sel_ack(cur_sel_r, a1_s, a2_s);
        a_new_s  = sel_ack(sel_r, a1_s, a2_s);
        accept_s = req_valid && req_ready_r;
    end

`ifdef CLK_SEL_TIMEOUT_EN
    logic [CNT_W-1:0] tcnt_r;
    logic             err_r;
    logic             tmo_s;

    // Timeout fires on the last allowed cycle of DRAIN+ENGAGE.
    always_comb begin
        tmo_s = (tcnt_r >= CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Switch-time budget: cleared on acceptance, saturating count in DRAIN/ENGAGE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            tcnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_DRAIN || state_r == ST_ENGAGE) && (tcnt_r != {CNT_W{1'b1}})) begin
            tcnt_r <= tcnt_r + CNT_W'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    assign err = err_r;
`else
    logic unused_s;
    assign unused_s = err_clr ^ (TIMEOUT_CYCLES == 0);
    assign err      = 1'b0;
`endif

    // Switch sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cur_sel_r   <= SEL_CLK1;
            sel_r       <= SEL_CLK1;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dcnt_r      <= {CNT_W{1'b0}};
`ifdef CLK_SEL_TIMEOUT_EN
            err_r       <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (req_sel == cur_sel_r)) begin
                        done_r <= 1'b1;
                    end else if (accept_s) begin
                        sel_r       <= req_sel;
                        state_r     <= ST_DRAIN;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!a_old_s) begin
                        state_r <= ST_ENGAGE;
`ifdef CLK_SEL_TIMEOUT_EN
                    end else if (tmo_s) begin
                        state_r <= ST_ERR;
                        err_r   <= 1'b1;
`endif
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_ENGAGE: begin
                    if (a_new_s) begin
                        cur_sel_r <= sel_r;
                        dcnt_r    <= {CNT_W{1'b0}};
                        state_r   <= ST_SETTLE;
`ifdef CLK_SEL_TIMEOUT_EN
                    end else if (tmo_s) begin
                        state_r <= ST_ERR;
                        err_r   <= 1'b1;
`endif
                    end else begin
                        state_r <= ST_ENGAGE;
                    end
                end
                ST_SETTLE: begin
                    if (dcnt_r >= CNT_W'(DWELL_CYCLES - 1)) begin
                        done_r      <= 1'b1;
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        dcnt_r <= dcnt_r + CNT_W'(1);
                    end
                end
`ifdef CLK_SEL_TIMEOUT_EN
                ST_ERR: begin
                    if (err_clr) begin
                        state_r     <= ST_IDLE;
                        cur_sel_r   <= sel_r;
                        err_r       <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end
`endif
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = sel_r;
    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl with a behavioural mux model driving ack_1/ack_2.
module tb_clk_sel_ctrl;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic req_valid = 1'b0;
    logic req_sel   = 1'b0;
    logic ack_1     = 1'b1;
    logic ack_2     = 1'b0;
    logic err_clr   = 1'b0;
    logic req_ready, sel, busy, done, err;

    int   n_vec  = 0;
    int   n_miss = 0;

    logic mux_tgt   = 1'b0;
    logic mux_stuck = 1'b0;
    int   mux_cnt   = 100;

    clk_sel_ctrl #(
        .SYNC_STAGES(2), .DWELL_CYCLES(16), .TIMEOUT_CYCLES(255), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .ack_1(ack_1), .ack_2(ack_2), .err_clr(err_clr),
        .sel(sel), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Mux model: old branch drops 3 cycles after sel moves, new branch rises 3 later.
    always @(negedge clk) begin
        if (sel !== mux_tgt) begin
            mux_tgt = sel;
            mux_cnt = 0;
        end else if (mux_cnt < 100) begin
            mux_cnt = mux_cnt + 1;
        end
        if (mux_cnt == 3) begin
            if (mux_tgt) ack_1 = 1'b0;
            else         ack_2 = 1'b0;
        end
        if (mux_cnt == 6 && !mux_stuck) begin
            if (mux_tgt) ack_2 = 1'b1;
            else         ack_1 = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until done pulses (or limit); report cycle index, busy-low and ready-high counts before it.
    task automatic wait_done(input int limit, output int at, output int busy_low, output int rdy_hi);
        at = -1; busy_low = 0; rdy_hi = 0;
        for (int k = 1; k <= limit && at < 0; k++) begin
            step();
            if (done) begin
                at = k;
            end else begin
                if (!busy)     busy_low++;
                if (req_ready) rdy_hi++;
            end
        end
    endtask

    int at, bl, rh, err_at, ready_hi, err_hi;

    initial begin
        #12;
        chk("rst_sel",   32'(sel),       32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_err",   32'(err),       32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Same-select request: no switch, done next cycle, busy stays low.
        req_valid = 1'b1; req_sel = 1'b0;
        step();
        req_valid = 1'b0;
        chk("same_done",  32'(done),      32'd1);
        chk("same_busy",  32'(busy),      32'd0);
        chk("same_sel",   32'(sel),       32'd0);
        chk("same_ready", 32'(req_ready), 32'd1);
        step();
        chk("same_done_end", 32'(done), 32'd0);

        // Full switch to clk_2.
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        chk("sw1_sel",   32'(sel),       32'd1);
        chk("sw1_busy",  32'(busy),      32'd1);
        chk("sw1_ready", 32'(req_ready), 32'd0);
        wait_done(60, at, bl, rh);
        chk("sw1_done_at",  32'(at), 32'd25);
        chk("sw1_busy_low", 32'(bl), 32'd0);
        chk("sw1_rdy_hi",   32'(rh), 32'd0);
        chk("sw1_ready_end", 32'(req_ready), 32'd1);
        chk("sw1_busy_end",  32'(busy),      32'd0);
        step();
        chk("sw1_done_single", 32'(done), 32'd0);

        // cur_sel is now clk_2: re-requesting it is a no-op.
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        chk("cur2_done", 32'(done), 32'd1);
        chk("cur2_busy", 32'(busy), 32'd0);
        step();

        // Back-to-back: valid held, second request only after done.
        req_valid = 1'b1; req_sel = 1'b0;
        step();
        chk("b2b1_sel", 32'(sel), 32'd0);
        req_sel = 1'b1;
        wait_done(60, at, bl, rh);
        chk("b2b1_done_at", 32'(at), 32'd25);
        chk("b2b1_rdy_hi",  32'(rh), 32'd0);
        chk("b2b1_ready",   32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("b2b2_sel",  32'(sel),  32'd1);
        chk("b2b2_busy", 32'(busy), 32'd1);
        wait_done(60, at, bl, rh);
        chk("b2b2_done_at", 32'(at), 32'd25);

        // Back to clk_1, then reset while engaging clk_2.
        req_valid = 1'b1; req_sel = 1'b0;
        step();
        req_valid = 1'b0;
        wait_done(60, at, bl, rh);
        chk("ret_done_at", 32'(at), 32'd25);
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("eng_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_sel",   32'(sel),       32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_done",  32'(done),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) step();
        req_valid = 1'b1; req_sel = 1'b0;
        step();
        req_valid = 1'b0;
        chk("arst_cur_done", 32'(done), 32'd1);
        chk("arst_cur_busy", 32'(busy), 32'd0);
        step();

        // Stuck new-branch enable.
        mux_stuck = 1'b1;
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        chk("stk_sel", 32'(sel), 32'd1);
        err_at = -1; bl = 0; ready_hi = 0; err_hi = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (!busy) bl++;
            if (req_ready) ready_hi++;
            if (err) err_hi++;
            if (err && err_at < 0) err_at = k;
        end
        chk("stk_busy_low", 32'(bl),       32'd0);
        chk("stk_ready_hi", 32'(ready_hi), 32'd0);
`ifdef CLK_SEL_TIMEOUT_EN
        chk("tmo_err_at", 32'(err_at), 32'd255);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err",   32'(err),       32'd0);
        chk("clr_ready", 32'(req_ready), 32'd1);
        chk("clr_busy",  32'(busy),      32'd0);
        chk("clr_sel",   32'(sel),       32'd1);
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        chk("clr_cur_done", 32'(done), 32'd1);
        chk("clr_cur_busy", 32'(busy), 32'd0);
`else
        chk("noto_err_hi", 32'(err_hi), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("noto_clr_busy", 32'(busy), 32'd1);
        chk("noto_clr_err",  32'(err),  32'd0);
`endif
        mux_stuck = 1'b0;
        reset = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
